cr_prefix_mc_dispatch: RTL

//  Frame-level dispatcher/collector that fans one inbound AXI4S datapath out to
//  N_CH parallel prefix cores and merges their outputs back onto one stream in

---
 rtl/cr_prefix_mc_dispatch_pkg.sv | 24 ++
 rtl/cr_prefix_mc_dispatch_if.sv | 27 ++
 rtl/cr_prefix_mc_order_fifo.sv | 46 ++++
 rtl/cr_prefix_mc_dispatch.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cr_prefix_mc_dispatch_pkg.sv
// Shared types for the multi-channel prefix dispatcher/collector.
package cr_prefix_mc_dispatch_pkg;
  localparam int MC_MAX_CH = 8;
  localparam int DP_W      = 64;

  // Sized for the largest channel count so one type serves every build.
  typedef logic [$clog2(MC_MAX_CH)-1:0] ch_idx_t;

  typedef enum logic {D_IDLE, D_FRAME} disp_state_e;

  typedef struct packed {
    logic            tvalid;
    logic            tlast;
    logic [DP_W-1:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  function automatic ch_idx_t ch_wrap_inc(ch_idx_t c, int n);
    return (int'(c) + 1 >= n) ? '0 : ch_idx_t'(c + 1'b1);
  endfunction
endpackage

// File: rtl/cr_prefix_mc_dispatch_if.sv
// Ingress/egress/channel streams plus error/stat sideband of the dispatcher.
interface cr_prefix_mc_dispatch_if import cr_prefix_mc_dispatch_pkg::*; #(
  parameter int N_CH = 4
);
  axi4s_dp_bus_t               prefix_ib_in;
  axi4s_dp_rdy_t               prefix_ib_out;
  axi4s_dp_bus_t [N_CH-1:0]    ch_ib_out;
  axi4s_dp_rdy_t [N_CH-1:0]    ch_ib_in;
  axi4s_dp_bus_t [N_CH-1:0]    ch_ob_in;
  axi4s_dp_rdy_t [N_CH-1:0]    ch_ob_out;
  axi4s_dp_bus_t               prefix_ob_out;
  axi4s_dp_rdy_t               prefix_ob_in;
  logic [N_CH-1:0]             ch_err;
  logic [N_CH-1:0]             err_clr;
  logic [N_CH-1:0]             err_stat;
  logic                        mc_int;
  logic [N_CH-1:0][31:0]       frm_cnt;

  modport master (
    output prefix_ib_in, ch_ib_in, ch_ob_in, prefix_ob_in, ch_err, err_clr,
    input  prefix_ib_out, ch_ib_out, ch_ob_out, prefix_ob_out, err_stat, mc_int, frm_cnt
  );
  modport slave (
    input  prefix_ib_in, ch_ib_in, ch_ob_in, prefix_ob_in, ch_err, err_clr,
    output prefix_ib_out, ch_ib_out, ch_ob_out, prefix_ob_out, err_stat, mc_int, frm_cnt
  );
endinterface

// File: rtl/cr_prefix_mc_order_fifo.sv
// Register FIFO holding the channel index of every frame in flight, oldest at head.
module cr_prefix_mc_order_fifo import cr_prefix_mc_dispatch_pkg::*; #(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  ch_idx_t push_ch,
  input  logic    pop,
  output ch_idx_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  ch_idx_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_ch;
  end
endmodule

// File: rtl/cr_prefix_mc_dispatch.sv
// Round-robin frame dispatcher / in-order collector for N_CH prefix cores.
// Optional per-channel frame counters: define CR_PREFIX_MC_STATS_EN.
module cr_prefix_mc_dispatch import cr_prefix_mc_dispatch_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int ORDER_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  cr_prefix_mc_dispatch_if.slave bus
);
  disp_state_e         state;
  ch_idx_t             rr_ptr, cur_ch, sel, route_ch, head;
  logic                sel_vld, route_en, ib_rdy, ib_xfer, push, pop;
  logic                fifo_full, fifo_empty;
  logic [N_CH-1:0]     rdy_vec;
  logic [2*N_CH-1:0]   rdy2;
  axi4s_dp_bus_t       ob_beat;
  logic [N_CH-1:0]     err_q;
  logic                mc_q;
  int                  idx;

  // Rotate readiness so bit 0 is the channel rr_ptr points at.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int j = 0; j < N_CH; j++) rdy_vec[j] = bus.ch_ib_in[j].tready;
    rdy2 = {rdy_vec, rdy_vec} >> rr_ptr;
    for (int k = 0; k < N_CH; k++) begin
      if (!sel_vld && rdy2[k]) begin
        sel_vld = 1'b1;
        idx     = int'(rr_ptr) + k;
        sel     = ch_idx_t'((idx >= N_CH) ? idx - N_CH : idx);
      end
    end
  end

  assign route_ch = (state == D_FRAME) ? cur_ch : sel;
  assign route_en = rst_n && ((state == D_FRAME) || (sel_vld && !fifo_full));

  always_comb begin
    ib_rdy = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      bus.ch_ib_out[j] = '0;
      if (route_en && route_ch == ch_idx_t'(j)) begin
        bus.ch_ib_out[j] = bus.prefix_ib_in;
        ib_rdy           = bus.ch_ib_in[j].tready;
      end
    end
  end

  assign bus.prefix_ib_out.tready = ib_rdy;
  assign ib_xfer = bus.prefix_ib_in.tvalid & ib_rdy;
  assign push    = (state == D_IDLE) & ib_xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= D_IDLE;
      rr_ptr <= '0;
      cur_ch <= '0;
    end else begin
      case (state)
        D_IDLE: if (push) begin
          cur_ch <= sel;
          rr_ptr <= ch_wrap_inc(sel, N_CH);
          if (!bus.prefix_ib_in.tlast) state <= D_FRAME;
        end
        D_FRAME: if (ib_xfer && bus.prefix_ib_in.tlast) state <= D_IDLE;
        default: state <= D_IDLE;
      endcase
    end
  end

  // Only the oldest outstanding channel may drain; the rest are held off.
  always_comb begin
    ob_beat = '0;
    for (int j = 0; j < N_CH; j++) begin
      bus.ch_ob_out[j] = '0;
      if (rst_n && !fifo_empty && head == ch_idx_t'(j)) begin
        ob_beat                 = bus.ch_ob_in[j];
        bus.ch_ob_out[j].tready = bus.prefix_ob_in.tready;
      end
    end
  end

  assign bus.prefix_ob_out = ob_beat;
  assign pop = ob_beat.tvalid & ob_beat.tlast & bus.prefix_ob_in.tready;

  cr_prefix_mc_order_fifo #(.DEPTH(ORDER_DEPTH)) u_order_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .push_ch (sel),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      mc_q  <= 1'b0;
    end else begin
      err_q <= (err_q & ~bus.err_clr) | bus.ch_err;
      mc_q  <= |err_q;
    end
  end

  assign bus.err_stat = err_q;
  assign bus.mc_int   = mc_q;

`ifdef CR_PREFIX_MC_STATS_EN
  logic [N_CH-1:0][31:0] frm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt_q <= '0;
    end else if (push) begin
      for (int j = 0; j < N_CH; j++)
        if (sel == ch_idx_t'(j) && frm_cnt_q[j] != '1) frm_cnt_q[j] <= frm_cnt_q[j] + 1'b1;
    end
  end

  assign bus.frm_cnt = frm_cnt_q;
`else
  assign bus.frm_cnt = '0;
`endif
endmodule
